// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencer for the 5-stage core: freeze/flush control for hazards,
// taken branches and multi-cycle data-memory waits, plus performance counters.
module hazard_stall_ctrl #(
  parameter bit          FWD_EN      = 1'b1,
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [3:0]       id_src1,
  input  logic [3:0]       id_src2,
  input  logic             id_two_src,
  input  logic             id_src1_used,
  input  logic [3:0]       exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [3:0]       mem_dest,
  input  logic             mem_wb_en,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_freeze,
  output logic             if_id_freeze,
  output logic             if_id_flush,
  output logic             id_ex_freeze,
  output logic             id_ex_flush,
  output logic             ex_mem_freeze,
  output logic             mem_wb_freeze,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] wait_count
);

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_e;

  localparam logic [15:0] TMO = 16'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  logic [15:0]      timer_q, timer_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic [CNT_W-1:0] wait_q, wait_d;

  logic exe_hit_s;
  logic mem_hit_s;
  logic hazard_s;
  logic hold_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Hazard detection: with forwarding only a load in EXE blocks the ID reader
  always_comb begin
    exe_hit_s = exe_wb_en && (!FWD_EN || exe_mem_r_en) &&
                ((id_src1_used && (id_src1 == exe_dest)) ||
                 (id_two_src   && (id_src2 == exe_dest)));
    mem_hit_s = !FWD_EN && mem_wb_en &&
                ((id_src1_used && (id_src1 == mem_dest)) ||
                 (id_two_src   && (id_src2 == mem_dest)));
    hazard_s  = id_valid && (exe_hit_s || mem_hit_s);
  end

  // Next-state, wait timer and counter updates
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    timeout_d = timeout_q;
    stall_d   = stall_q;
    flush_d   = flush_q;
    wait_d    = wait_q;
    hold_s    = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (mem_req && !mem_ready) begin
          hold_s  = 1'b1;
          state_d = ST_MEM_WAIT;
          timer_d = 16'd1;
          wait_d  = sat_inc(wait_q);
        end else begin
          hold_s  = 1'b0;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready) begin
          state_d = ST_RUN;
          timer_d = 16'd0;
        end else if (timer_q == TMO) begin
          // Abort: release the pipeline as if the access completed
          timeout_d = 1'b1;
          state_d   = ST_RUN;
          timer_d   = 16'd0;
        end else begin
          hold_s  = 1'b1;
          timer_d = timer_q + 16'd1;
          wait_d  = sat_inc(wait_q);
        end
      end
      default: begin
        state_d = ST_RUN;
        timer_d = 16'd0;
      end
    endcase
    if (hold_s) begin
      stall_d = stall_q;
    end else if (branch_taken) begin
      flush_d = sat_inc(flush_q);
    end else if (hazard_s) begin
      stall_d = sat_inc(stall_q);
    end else begin
      stall_d = stall_q;
    end
  end

  // Mealy freeze/flush outputs, forced low while reset is asserted
  always_comb begin
    pc_freeze     = 1'b0;
    if_id_freeze  = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_freeze  = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_freeze = 1'b0;
    mem_wb_freeze = 1'b0;
    if (!rst) begin
      pc_freeze = 1'b0;
    end else if (hold_s) begin
      pc_freeze     = 1'b1;
      if_id_freeze  = 1'b1;
      id_ex_freeze  = 1'b1;
      ex_mem_freeze = 1'b1;
      mem_wb_freeze = 1'b1;
    end else if (branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (hazard_s) begin
      pc_freeze    = 1'b1;
      if_id_freeze = 1'b1;
      id_ex_flush  = 1'b1;
    end else begin
      pc_freeze = 1'b0;
    end
  end

  // State and counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_RUN;
      timer_q   <= 16'd0;
      timeout_q <= 1'b0;
      stall_q   <= {CNT_W{1'b0}};
      flush_q   <= {CNT_W{1'b0}};
      wait_q    <= {CNT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
      stall_q   <= stall_d;
      flush_q   <= flush_d;
      wait_q    <= wait_d;
    end
  end

  assign mem_timeout = timeout_q;
  assign stall_count = stall_q;
  assign flush_count = flush_q;
  assign wait_count  = wait_q;

endmodule
